// File: rtl/gobang_pkg.sv
`default_nettype none
// ============================================================================
// Package : gobang_pkg
// Brief   : Board, cell, direction, type-code and scanner-state encodings.
// Rev     : 1.0 - initial release
// ============================================================================
package gobang_pkg;

    localparam int BOARD_N = 15;
    localparam int ADDR_W  = 8;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_BLACK = 2'b01,
        CELL_WHITE = 2'b10
    } cell_e;

    typedef enum logic [1:0] {
        DIR_H = 2'd0,
        DIR_V = 2'd1,
        DIR_D = 2'd2,
        DIR_A = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        TYPE_NONE  = 3'd0,
        TYPE_DEAD2 = 3'd1,
        TYPE_LIVE2 = 3'd2,
        TYPE_DEAD3 = 3'd3,
        TYPE_LIVE3 = 3'd4,
        TYPE_DEAD4 = 3'd5,
        TYPE_LIVE4 = 3'd6,
        TYPE_FIVE  = 3'd7
    } type_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_CHKW    = 3'd2,
        ST_FETCH   = 3'd3,
        ST_LAST    = 3'd4,
        ST_PRESENT = 3'd5,
        ST_DONE    = 3'd6
    } scan_state_e;

    function automatic logic [2:0] type_max(input logic [2:0] a, input logic [2:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_window_scanner_if.sv
`default_nettype none
// ============================================================================
// Interface : line_window_scanner_if
// Brief     : Controller, board-RAM and classifier signals of the scanner.
// Rev       : 1.0 - initial release
// ============================================================================
interface line_window_scanner_if #(
    parameter int ADDR_W = gobang_pkg::ADDR_W
) ();

    logic              start;
    logic [3:0]        row;
    logic [3:0]        col;
    logic [1:0]        player;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        rd_data;
    logic [8:0]        win_a;
    logic [8:0]        win_b;
    logic              win_valid;
    logic [1:0]        win_dir;
    logic [2:0]        type_in;
    logic              busy;
    logic              done;
    logic              illegal;
    logic [11:0]       dir_types;
    logic [2:0]        best_type;

    modport master (
        output start, row, col, player, rd_data, type_in,
        input  rd_en, rd_addr, win_a, win_b, win_valid, win_dir,
        input  busy, done, illegal, dir_types, best_type
    );

    modport slave (
        input  start, row, col, player, rd_data, type_in,
        output rd_en, rd_addr, win_a, win_b, win_valid, win_dir,
        output busy, done, illegal, dir_types, best_type
    );

endinterface
`default_nettype wire

// File: rtl/line_window_scanner_addr_gen.sv
`default_nettype none
// ============================================================================
// Module : line_addr_gen
// Brief  : Maps (row, col, dir, k) to a board RAM address and on-board flag.
// Rev    : 1.0 - initial release
// ============================================================================
module line_addr_gen #(
    parameter int BOARD_N = gobang_pkg::BOARD_N,
    parameter int ADDR_W  = gobang_pkg::ADDR_W
) (
    input  wire logic [3:0]        row,
    input  wire logic [3:0]        col,
    input  wire logic [1:0]        dir,
    input  wire logic [3:0]        k,
    output logic      [ADDR_W-1:0] addr,
    output logic                   on_board
);
    import gobang_pkg::*;

    localparam logic signed [5:0] C_EDGE = 6'(BOARD_N);

    logic signed [5:0] w_off;
    logic signed [5:0] w_r;
    logic signed [5:0] w_c;

    always_comb begin
        w_off = $signed({2'b00, k}) - 6'sd4;
        w_r   = $signed({2'b00, row});
        w_c   = $signed({2'b00, col});
        case (dir)
            DIR_H:   w_c = w_c + w_off;
            DIR_V:   w_r = w_r + w_off;
            DIR_D: begin
                w_r = w_r + w_off;
                w_c = w_c + w_off;
            end
            default: begin
                w_r = w_r + w_off;
                w_c = w_c - w_off;
            end
        endcase
    end

    assign on_board = (w_r >= 6'sd0) && (w_r < C_EDGE) &&
                      (w_c >= 6'sd0) && (w_c < C_EDGE);

    // Address is forced to 0 off-board so nothing downstream sees a wrapped index.
    assign addr = on_board ?
                  (ADDR_W'(w_r[3:0]) * ADDR_W'(BOARD_N) + ADDR_W'(w_c[3:0])) :
                  '0;

endmodule
`default_nettype wire

// File: rtl/line_window_scanner.sv
`default_nettype none
// ============================================================================
// Module : line_window_scanner
// Brief  : Builds the four 9-cell own/blocker windows around a candidate move,
//          hands each to the classifier and collects the per-direction types.
// Rev    : 1.0 - initial release
// ============================================================================
module line_window_scanner #(
    parameter int BOARD_N = gobang_pkg::BOARD_N,
    parameter int ADDR_W  = gobang_pkg::ADDR_W
) (
    input  wire logic            clk,
    input  wire logic            rst,
    line_window_scanner_if.slave bus
);
    import gobang_pkg::*;

    scan_state_e       state_q,     state_d;
    logic [3:0]        row_q,       row_d;
    logic [3:0]        col_q,       col_d;
    logic [1:0]        player_q,    player_d;
    logic [1:0]        dir_q,       dir_d;
    logic [3:0]        k_q,         k_d;
    logic              bad_q,       bad_d;
    logic              pend_on_q,   pend_on_d;
    logic [8:0]        sh_a_q,      sh_a_d;
    logic [8:0]        sh_b_q,      sh_b_d;
    logic              rd_en_q,     rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;
    logic [8:0]        win_a_q,     win_a_d;
    logic [8:0]        win_b_q,     win_b_d;
    logic              win_valid_q, win_valid_d;
    logic [1:0]        win_dir_q,   win_dir_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              illegal_q,   illegal_d;
    logic [11:0]       dir_types_q, dir_types_d;
    logic [2:0]        best_type_q, best_type_d;

    logic [3:0]        w_gen_k;
    logic [ADDR_W-1:0] w_gen_addr;
    logic              w_gen_on;
    logic [3:0]        w_cap_idx;
    logic              w_cell_a;
    logic              w_cell_b;

    // Address is generated for the state being entered so rd_en/rd_addr are flops.
    assign w_gen_k = (state_d == ST_CHECK) ? 4'd4 : k_d;

    line_addr_gen #(
        .BOARD_N (BOARD_N),
        .ADDR_W  (ADDR_W)
    ) u_addr_gen (
        .row      (row_d),
        .col      (col_d),
        .dir      (dir_d),
        .k        (w_gen_k),
        .addr     (w_gen_addr),
        .on_board (w_gen_on)
    );

    assign rd_en_d     = ((state_d == ST_CHECK) || (state_d == ST_FETCH)) && w_gen_on;
    assign rd_addr_d   = rd_en_d ? w_gen_addr : '0;
    assign pend_on_d   = rd_en_q;
    assign busy_d      = (state_d != ST_IDLE);
    assign done_d      = (state_d == ST_DONE);
    assign win_valid_d = (state_d == ST_PRESENT);

    // The cell arriving now belongs to the window index fetched last cycle.
    assign w_cap_idx = (state_q == ST_LAST) ? 4'd8 : (k_q - 4'd1);

    always_comb begin
        w_cell_a = 1'b0;
        w_cell_b = 1'b0;
        if (w_cap_idx == 4'd4) begin
            w_cell_a = 1'b1;
        end else if (!pend_on_q) begin
            w_cell_b = 1'b1;
        end else if (bus.rd_data == player_q) begin
            w_cell_a = 1'b1;
        end else if (bus.rd_data != CELL_EMPTY) begin
            w_cell_b = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        player_d    = player_q;
        dir_d       = dir_q;
        k_d         = k_q;
        bad_d       = bad_q;
        sh_a_d      = sh_a_q;
        sh_b_d      = sh_b_q;
        win_a_d     = win_a_q;
        win_b_d     = win_b_q;
        win_dir_d   = win_dir_q;
        illegal_d   = illegal_q;
        dir_types_d = dir_types_q;
        best_type_d = best_type_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d     = ST_CHECK;
                    row_d       = bus.row;
                    col_d       = bus.col;
                    player_d    = bus.player;
                    dir_d       = 2'd0;
                    k_d         = 4'd0;
                    illegal_d   = 1'b0;
                    dir_types_d = '0;
                    best_type_d = TYPE_NONE;
                end
            end
            ST_CHECK: begin
                // A centre read was issued exactly when the candidate is on-board.
                bad_d   = !rd_en_q;
                state_d = ST_CHKW;
            end
            ST_CHKW: begin
                if (bad_q || (bus.rd_data != CELL_EMPTY)) begin
                    illegal_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    dir_d   = 2'd0;
                    k_d     = 4'd0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (k_q != 4'd0) begin
                    sh_a_d = {w_cell_a, sh_a_q[8:1]};
                    sh_b_d = {w_cell_b, sh_b_q[8:1]};
                end
                if (k_q == 4'd8) begin
                    state_d = ST_LAST;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            ST_LAST: begin
                sh_a_d    = {w_cell_a, sh_a_q[8:1]};
                sh_b_d    = {w_cell_b, sh_b_q[8:1]};
                win_a_d   = {w_cell_a, sh_a_q[8:1]};
                win_b_d   = {w_cell_b, sh_b_q[8:1]};
                win_dir_d = dir_q;
                state_d   = ST_PRESENT;
            end
            ST_PRESENT: begin
                for (int d = 0; d < 4; d++) begin
                    if (dir_q == 2'(d)) begin
                        dir_types_d[3*d +: 3] = bus.type_in;
                    end
                end
                if (dir_q == 2'd3) begin
                    best_type_d = TYPE_NONE;
                    for (int d = 0; d < 4; d++) begin
                        best_type_d = type_max(best_type_d, dir_types_d[3*d +: 3]);
                    end
                    state_d = ST_DONE;
                end else begin
                    dir_d   = dir_q + 2'd1;
                    k_d     = 4'd0;
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            player_q    <= '0;
            dir_q       <= '0;
            k_q         <= '0;
            bad_q       <= 1'b0;
            pend_on_q   <= 1'b0;
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            win_a_q     <= '0;
            win_b_q     <= '0;
            win_valid_q <= 1'b0;
            win_dir_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            dir_types_q <= '0;
            best_type_q <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            player_q    <= player_d;
            dir_q       <= dir_d;
            k_q         <= k_d;
            bad_q       <= bad_d;
            pend_on_q   <= pend_on_d;
            sh_a_q      <= sh_a_d;
            sh_b_q      <= sh_b_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            win_a_q     <= win_a_d;
            win_b_q     <= win_b_d;
            win_valid_q <= win_valid_d;
            win_dir_q   <= win_dir_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            illegal_q   <= illegal_d;
            dir_types_q <= dir_types_d;
            best_type_q <= best_type_d;
        end
    end

    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.win_a     = win_a_q;
    assign bus.win_b     = win_b_q;
    assign bus.win_valid = win_valid_q;
    assign bus.win_dir   = win_dir_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.illegal   = illegal_q;
    assign bus.dir_types = dir_types_q;
    assign bus.best_type = best_type_q;

endmodule
`default_nettype wire

// File: tb/tb_line_window_scanner.sv
`default_nettype none
// ============================================================================
// Module : tb_line_window_scanner
// Brief  : Scoreboard bench: board RAM model, classifier stub, window/result
//          expectations derived from a reference model of the board.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_line_window_scanner;

    localparam int N = 15;
    localparam int P = 10;

    typedef struct {
        logic [8:0] a;
        logic [8:0] b;
        logic [1:0] dir;
        int         cyc;
    } win_exp_t;

    typedef struct {
        logic        ill;
        logic [11:0] types;
        logic [2:0]  best;
        int          cyc;
        int          reads;
    } res_exp_t;

    logic clk = 1'b0;
    logic rst;

    line_window_scanner_if #(.ADDR_W(8)) bus ();

    line_window_scanner #(
        .BOARD_N (15),
        .ADDR_W  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #(P/2) clk = ~clk;

    logic [1:0] board [N][N];
    logic [2:0] cls [4];

    int       checks   = 0;
    int       failures = 0;
    win_exp_t wq[$];
    res_exp_t rq[$];
    time      t_start;
    bit       active;
    int       reads_seen;
    int       mon_n;
    win_exp_t mon_we;
    res_exp_t mon_re;

    assign bus.type_in = cls[bus.win_dir];

    // Board RAM: one-cycle latency, junk on cycles with no read.
    always @(posedge clk) begin
        if (bus.rd_en && (bus.rd_addr < 8'(N*N)))
            bus.rd_data <= board[int'(bus.rd_addr) / N][int'(bus.rd_addr) % N];
        else
            bus.rd_data <= 2'b11;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        check_eq({tag, "_ctl"}, 32'({bus.rd_en, bus.rd_addr, bus.win_valid, bus.win_dir,
                                     bus.busy, bus.done, bus.illegal}), 32'(0));
        check_eq({tag, "_win"}, 32'({bus.win_a, bus.win_b}), 32'(0));
        check_eq({tag, "_res"}, 32'({bus.dir_types, bus.best_type}), 32'(0));
    endtask

    function automatic bit on_brd(input int r, input int c);
        return (r >= 0) && (r < N) && (c >= 0) && (c < N);
    endfunction

    function automatic int step_r(input int d);
        return (d == 0) ? 0 : 1;
    endfunction

    function automatic int step_c(input int d);
        return (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 1 : -1;
    endfunction

    function automatic logic [17:0] model_win(input int r, input int c, input logic [1:0] p, input int d);
        logic [8:0] a;
        logic [8:0] b;
        int rr;
        int cc;
        a = '0;
        b = '0;
        for (int k = 0; k < 9; k++) begin
            rr = r + (k - 4) * step_r(d);
            cc = c + (k - 4) * step_c(d);
            if (k == 4)                    a[k] = 1'b1;
            else if (!on_brd(rr, cc))      b[k] = 1'b1;
            else if (board[rr][cc] == p)   a[k] = 1'b1;
            else if (board[rr][cc] != 2'b00) b[k] = 1'b1;
        end
        return {b, a};
    endfunction

    function automatic int model_reads(input int r, input int c, input int d);
        int cnt;
        cnt = 0;
        for (int k = 0; k < 9; k++)
            if (on_brd(r + (k - 4) * step_r(d), c + (k - 4) * step_c(d))) cnt++;
        return cnt;
    endfunction

    task automatic clear_board();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                board[r][c] = 2'b00;
    endtask

    always @(negedge clk) begin
        if (active) begin
            mon_n = int'((($time - t_start) - P/2) / P) + 1;
            if (bus.rd_en) reads_seen++;
            if (bus.win_valid) begin
                if (wq.size() == 0) begin
                    check_eq("win_unexpected", 32'(bus.win_valid), 32'(0));
                end else begin
                    mon_we = wq.pop_front();
                    check_eq("win_a",   32'(bus.win_a),   32'(mon_we.a));
                    check_eq("win_b",   32'(bus.win_b),   32'(mon_we.b));
                    check_eq("win_dir", 32'(bus.win_dir), 32'(mon_we.dir));
                    check_eq("win_cyc", 32'(mon_n),       32'(mon_we.cyc));
                end
            end
            if (bus.done) begin
                if (rq.size() == 0) begin
                    check_eq("done_unexpected", 32'(bus.done), 32'(0));
                end else begin
                    mon_re = rq.pop_front();
                    check_eq("illegal",   32'(bus.illegal),   32'(mon_re.ill));
                    check_eq("dir_types", 32'(bus.dir_types), 32'(mon_re.types));
                    check_eq("best_type", 32'(bus.best_type), 32'(mon_re.best));
                    check_eq("done_cyc",  32'(mon_n),         32'(mon_re.cyc));
                    check_eq("reads",     32'(reads_seen),    32'(mon_re.reads));
                end
            end
        end
    end

    task automatic run_scan(input int r, input int c, input logic [1:0] p,
                            input logic [2:0] t0, input logic [2:0] t1,
                            input logic [2:0] t2, input logic [2:0] t3,
                            input int repulse, input int rst_at);
        logic [11:0] types;
        logic [2:0]  best;
        logic        ill;
        logic [17:0] w;
        win_exp_t    we;
        res_exp_t    re;
        int          n;
        bit          stop;

        cls[0] = t0; cls[1] = t1; cls[2] = t2; cls[3] = t3;
        types = {t3, t2, t1, t0};
        best  = 3'd0;
        for (int d = 0; d < 4; d++)
            if (types[3*d +: 3] > best) best = types[3*d +: 3];

        ill      = 1'b1;
        re.reads = 0;
        if (r < N && c < N) begin
            re.reads = 1;
            ill = (board[r][c] != 2'b00);
        end
        if (!ill) begin
            for (int d = 0; d < 4; d++) begin
                w      = model_win(r, c, p, d);
                we.a   = w[8:0];
                we.b   = w[17:9];
                we.dir = 2'(d);
                we.cyc = 13 + 11 * d;
                re.reads += model_reads(r, c, d);
                if (rst_at == 0 || we.cyc <= rst_at) wq.push_back(we);
            end
        end
        re.ill   = ill;
        re.types = ill ? 12'd0 : types;
        re.best  = ill ? 3'd0 : best;
        re.cyc   = ill ? 3 : 47;
        if (rst_at == 0) rq.push_back(re);

        @(negedge clk);
        bus.row    = 4'(r);
        bus.col    = 4'(c);
        bus.player = p;
        bus.start  = 1'b1;
        @(posedge clk);
        t_start    = $time;
        reads_seen = 0;
        active     = 1'b1;
        @(negedge clk);
        n    = 1;
        stop = 1'b0;
        while (!stop) begin
            bus.start = (n == repulse);
            rst       = (rst_at != 0) && (n == rst_at);
            if (rst_at != 0 && n == rst_at + 1) chk_all_zero("abort");
            if (rst_at != 0 && n >= rst_at + 30) begin
                stop = 1'b1;
            end else if (rst_at == 0 && bus.done) begin
                stop = 1'b1;
            end else if (n >= 200) begin
                check_eq("done_timeout", 32'(bus.done), 32'(1));
                stop = 1'b1;
            end else begin
                @(negedge clk);
                n++;
            end
        end

        if (rst_at == 0) begin
            @(negedge clk);
            bus.start = 1'b0;
            check_eq("idle_busy",    32'(bus.busy),      32'(0));
            check_eq("hold_types",   32'(bus.dir_types), 32'(re.types));
            check_eq("hold_best",    32'(bus.best_type), 32'(re.best));
            check_eq("hold_illegal", 32'(bus.illegal),   32'(re.ill));
        end else begin
            bus.start = 1'b0;
            rst       = 1'b0;
            check_eq("abort_winq", 32'(wq.size()), 32'(0));
        end
    endtask

    initial begin
        rst        = 1'b1;
        active     = 1'b0;
        reads_seen = 0;
        bus.start  = 1'b0;
        bus.row    = '0;
        bus.col    = '0;
        bus.player = '0;
        for (int d = 0; d < 4; d++) cls[d] = 3'd0;
        clear_board();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");

        run_scan(7, 7, 2'b01, 3'd2, 3'd3, 3'd1, 3'd4, 0, 0);

        for (int c = 3; c <= 6; c++) board[7][c] = 2'b01;
        run_scan(7, 7, 2'b01, 3'd5, 3'd0, 3'd0, 3'd1, 0, 0);

        // Start pulsed during DONE must be ignored.
        board[7][8] = 2'b10;
        run_scan(7, 7, 2'b01, 3'd6, 3'd2, 3'd7, 3'd0, 47, 0);

        clear_board();
        run_scan(0, 0, 2'b10, 3'd1, 3'd1, 3'd1, 3'd1, 0, 0);

        board[7][7] = 2'b10;
        run_scan(7, 7, 2'b01, 3'd3, 3'd3, 3'd3, 3'd3, 0, 0);

        clear_board();
        run_scan(15, 2, 2'b01, 3'd3, 3'd3, 3'd3, 3'd3, 0, 0);

        run_scan(3, 12, 2'b01, 3'd0, 3'd5, 3'd2, 3'd1, 10, 0);

        run_scan(7, 7, 2'b01, 3'd2, 3'd2, 3'd2, 3'd2, 0, 20);

        board[13][13] = 2'b10;
        board[14][12] = 2'b01;
        board[12][14] = 2'b10;
        run_scan(14, 14, 2'b10, 3'd4, 3'd6, 3'd3, 3'd5, 0, 0);

        active = 1'b0;
        check_eq("winq_left", 32'(wq.size()), 32'(0));
        check_eq("resq_left", 32'(rq.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
